multiport_reg_file: RTL
=======================

// Module: multiport_reg_file
// PURPOSE
//  Parametrised next-generation register file for the MIPS datapath: NUM_READ async read ports,
//  two sync write ports (W0 = ALU writeback, W1 = load writeback), optional write-first bypass,
//  hardwired zero register, and a per-register pending scoreboard for outstanding loads.
//  Sits between decode (reads, marks) and writeback (writes); all reset synchronous.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; depth = 2**ADDR_W
//  NUM_READ  2   number of read ports (>=1)
//  BYPASS    1   1: read of a register written this cycle returns the incoming write data
//  ZERO_REG  1   1: register 0 reads 0, ignores writes, never pending
// PORTS
//  clk          in   1                  rising-edge clock
//  reset        in   1                  synchronous, active-high
//  read_reg     in   NUM_READ*ADDR_W    read addresses; port i = bits [i*ADDR_W +: ADDR_W]
//  read_data    out  NUM_READ*DATA_W    read data; port i = bits [i*DATA_W +: DATA_W]
//  read_pending out  NUM_READ           1 = addressed register awaits a load (stall request)
//  w0_en        in   1                  write enable, port 0
//  w0_reg       in   ADDR_W             write address, port 0
//  w0_data      in   DATA_W             write data, port 0
//  w1_en        in   1                  write enable, port 1; also clears pending bit
//  w1_reg       in   ADDR_W             write address, port 1
//  w1_data      in   DATA_W             write data, port 1
//  mark_en      in   1                  set pending bit of mark_reg (load issued)
//  mark_reg     in   ADDR_W             register to mark pending
//  pending_cnt  out  ADDR_W+1           number of registers currently pending
// BEHAVIOUR
//  - Reset (clk edge with reset=1): all registers <= 0, all pending <= 0, pending_cnt <= 0;
//    writes/marks in that cycle ignored. Mid-operation reset discards outstanding loads.
//  - Writes take effect at rising clk; stored value visible on read_data same cycle after edge.
//  - W0 and W1 same address same cycle: W1 data stored (load wins); both otherwise independent.
//  - ZERO_REG=1: writes/marks to reg 0 dropped; read_data for addr 0 = 0, read_pending = 0.
//  - Read path combinational, no delays. BYPASS=1: if w1_en & w1_reg==addr, return w1_data;
//    else if w0_en & w0_reg==addr, return w0_data; else stored value (zero-reg rule first).
//    BYPASS=0: stored value only (old value during write cycle).
//  - Scoreboard per register p[r]: next p[r] = mark hit ? 1 : (w1 hit ? 0 : p[r]).
//    Mark and W1 clear on same reg same cycle -> stays pending (new load supersedes).
//    W0 writes never clear pending. Mark of already-pending reg: no change, no count change.
//  - read_pending[i] = p[addr] & ~(BYPASS & w1_en & w1_reg==addr); combinational.
//  - pending_cnt: registered, equals popcount(p) every cycle; +1 on new set, -1 on clear,
//    net 0 when one set and a different one clears; max 2**ADDR_W-ZERO_REG, never wraps.
// TESTING
//  1 Reset, then read all 32 regs on both ports -> every read_data = 0, pending_cnt = 0.
//  2 w0 reg5=0xABCDEF12; same cycle read 5 -> BYPASS=1: 0xABCDEF12; BYPASS=0: 0; next cycle both 0xABCDEF12.
//  3 w0 reg7=0x11, w1 reg7=0x22 same cycle -> reg7 = 0x22; write 0xFFFFFFFF to reg0 -> reads 0.
//  4 mark reg9; next cycle read 9 -> read_pending=1, pending_cnt=1; w1 reg9=0x99 -> bypass
//    clears pending same cycle, next cycle p=0, cnt=0, data 0x99.
//  5 mark reg3 with w1 reg3 same cycle -> reg3 updated, still pending, cnt unchanged at 1;
//    mark regs 1..31 then reset mid-sequence -> cnt 0, all pending 0 next cycle.
//  6 NUM_READ=4, DATA_W=64, ADDR_W=6: random writes vs reference model, 10k cycles, all ports match.

Source files
------------

// File: rtl/multiport_reg_file_if.sv
// Register-file access bus: read ports, two write ports, load-pending mark and status.
interface multiport_reg_file_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_READ = 2
);

  logic [NUM_READ*ADDR_W-1:0] read_reg;
  logic [NUM_READ*DATA_W-1:0] read_data;
  logic [NUM_READ-1:0]        read_pending;
  logic                       w0_en;
  logic [ADDR_W-1:0]          w0_reg;
  logic [DATA_W-1:0]          w0_data;
  logic                       w1_en;
  logic [ADDR_W-1:0]          w1_reg;
  logic [DATA_W-1:0]          w1_data;
  logic                       mark_en;
  logic [ADDR_W-1:0]          mark_reg;
  logic [ADDR_W:0]            pending_cnt;

  // Decode/writeback side drives requests and consumes read results.
  modport master (
    output read_reg, w0_en, w0_reg, w0_data, w1_en, w1_reg, w1_data, mark_en, mark_reg,
    input  read_data, read_pending, pending_cnt
  );

  // Register file side.
  modport slave (
    input  read_reg, w0_en, w0_reg, w0_data, w1_en, w1_reg, w1_data, mark_en, mark_reg,
    output read_data, read_pending, pending_cnt
  );

endinterface

// File: rtl/multiport_reg_file.sv
// Multi-port register file with two write ports, optional write-first bypass,
// hardwired zero register and a per-register load-pending scoreboard.
module multiport_reg_file #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_READ = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input logic                clk,
  input logic                reset,
  multiport_reg_file_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0]          regs [DEPTH];
  logic [DEPTH-1:0]           pend;
  logic [DEPTH-1:0]           pend_next;
  logic [CNT_W-1:0]           cnt;
  logic [CNT_W-1:0]           cnt_next;
  logic                       w0_ok;
  logic                       w1_ok;
  logic                       mark_ok;
  logic                       set_new;
  logic                       clr_old;
  logic [ADDR_W-1:0]          ra;
  logic                       w0_hit;
  logic                       w1_hit;
  logic [NUM_READ*DATA_W-1:0] rd;
  logic [NUM_READ-1:0]        rp;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Qualify writes/marks against the hardwired zero register.
  always_comb begin
    w0_ok   = bus.w0_en && !is_zero(bus.w0_reg);
    w1_ok   = bus.w1_en && !is_zero(bus.w1_reg);
    mark_ok = bus.mark_en && !is_zero(bus.mark_reg);
  end

  // Scoreboard next state: a new mark beats a same-cycle load completion.
  always_comb begin
    pend_next = pend;
    if (w1_ok) pend_next[bus.w1_reg] = 1'b0;
    if (mark_ok) pend_next[bus.mark_reg] = 1'b1;
  end

  // Incremental pending count tracking only real 0->1 and 1->0 transitions.
  always_comb begin
    set_new  = mark_ok && !pend[bus.mark_reg];
    clr_old  = w1_ok && pend[bus.w1_reg] && !(mark_ok && (bus.mark_reg == bus.w1_reg));
    cnt_next = cnt + CNT_W'(set_new) - CNT_W'(clr_old);
  end

  // Register storage; W1 is applied last so the load result wins a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < DEPTH; r++) regs[ADDR_W'(r)] <= '0;
    end else begin
      if (w0_ok) regs[bus.w0_reg] <= bus.w0_data;
      if (w1_ok) regs[bus.w1_reg] <= bus.w1_data;
    end
  end

  // Scoreboard and its population count.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
      cnt  <= '0;
    end else begin
      pend <= pend_next;
      cnt  <= cnt_next;
    end
  end

  // Combinational read ports: zero register first, then W1, then W0 bypass, then storage.
  always_comb begin
    rd     = '0;
    rp     = '0;
    ra     = '0;
    w0_hit = 1'b0;
    w1_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      ra     = bus.read_reg[i*ADDR_W +: ADDR_W];
      w1_hit = (BYPASS != 0) && bus.w1_en && (bus.w1_reg == ra);
      w0_hit = (BYPASS != 0) && bus.w0_en && (bus.w0_reg == ra);
      if (is_zero(ra)) begin
        rd[i*DATA_W +: DATA_W] = '0;
        rp[i]                  = 1'b0;
      end else begin
        if (w1_hit)      rd[i*DATA_W +: DATA_W] = bus.w1_data;
        else if (w0_hit) rd[i*DATA_W +: DATA_W] = bus.w0_data;
        else             rd[i*DATA_W +: DATA_W] = regs[ra];
        rp[i] = pend[ra] && !w1_hit;
      end
    end
  end

  assign bus.read_data    = rd;
  assign bus.read_pending = rp;
  assign bus.pending_cnt  = cnt;

endmodule
